// File: rtl/rom_boot_copier_pkg.sv
// Shared definitions for the ROM-to-RAM boot copier: FSM encoding and FIFO sizing.
package rom_boot_copier_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam int FIFO_DEPTH = 2;
  localparam int DATA_W     = 32;

endpackage

// File: rtl/rom_boot_copier_copy_fifo2.sv
// Two-entry 32-bit FIFO buffering ROM read data ahead of the RAM write stage,
// plus its overflow/underflow checker.
module copy_fifo2
  import rom_boot_copier_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] ent0_r;
  logic [DATA_W-1:0] ent1_r;
  logic [1:0]        count_r;

  // Shift-style storage: entry 0 is always the head of the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ent0_r  <= 32'h0000_0000;
      ent1_r  <= 32'h0000_0000;
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) ent0_r <= din;
          else                 ent1_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            ent0_r <= din;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign count = count_r;
  assign head  = ent0_r;

  copy_fifo2_chk u_chk (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .count (count_r)
  );

endmodule

module copy_fifo2_chk
  import rom_boot_copier_pkg::*;
(
  input logic       CLK,
  input logic       RST,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  // The issue throttle upstream must never let the FIFO overflow or underflow.
  always @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && !pop && (count == 2'(FIFO_DEPTH))));
      assert (!(pop && (count == 2'd0)));
    end
  end

endmodule

// File: rtl/rom_boot_copier.sv
// Boot copier: streams COUNT words from the ROM macro into the boot SRAM,
// throttling ROM reads so in-flight data always fits the 2-entry FIFO.
module rom_boot_copier
  import rom_boot_copier_pkg::*;
#(
  parameter  int MEM_WORDS = 8192,
  parameter  int DST_AW    = 14,
  localparam int ADR_WIDTH = $clog2(MEM_WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [ADR_WIDTH-1:0] src_base,
  input  logic [DST_AW-1:0]    dst_base,
  input  logic [ADR_WIDTH:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_EN,
  output logic [ADR_WIDTH-1:0] rom_A,
  input  logic [31:0]          rom_Do,
  output logic                 ram_WE,
  output logic [DST_AW-1:0]    ram_A,
  output logic [31:0]          ram_Di,
  input  logic                 ram_ready
);

  localparam int CW = ADR_WIDTH + 1;

  logic [1:0]           state_r, state_nxt_s;
  logic                 busy_r, done_r;
  logic [ADR_WIDTH-1:0] rom_a_r;
  logic [CW-1:0]        reads_rem_r, writes_rem_r;
  logic                 rd_pending_r;
  logic                 ram_we_r;
  logic [DST_AW-1:0]    ram_a_r;
  logic [31:0]          ram_di_r;

  logic        pop_s, rom_en_s, load_s, fifo_empty_s;
  logic        fifo_push_s, fifo_pop_s, bypass_s, wr_valid_s;
  logic [2:0]  occ_s, limit_s;
  logic [1:0]  fifo_count_s;
  logic [31:0] fifo_head_s, wr_data_s;

  // Read throttle and write-stage feed; an empty FIFO lets fresh ROM data bypass it.
  always_comb begin
    pop_s        = ram_we_r && ram_ready;
    occ_s        = {1'b0, fifo_count_s} + {2'b00, rd_pending_r};
    limit_s      = 3'd1 + {2'b00, pop_s};
    rom_en_s     = (state_r == ST_RUN) && (reads_rem_r != '0) && (occ_s <= limit_s);
    load_s       = !ram_we_r || ram_ready;
    fifo_empty_s = (fifo_count_s == 2'd0);
    fifo_pop_s   = load_s && !fifo_empty_s;
    bypass_s     = load_s && fifo_empty_s && rd_pending_r;
    fifo_push_s  = rd_pending_r && !bypass_s;
    wr_valid_s   = fifo_pop_s || bypass_s;
    if (fifo_empty_s) wr_data_s = rom_Do;
    else              wr_data_s = fifo_head_s;
  end

  // Next-state logic for IDLE -> RUN/FINISH -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = (count == '0) ? ST_FINISH : ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (pop_s && (writes_rem_r == CW'(1))) state_nxt_s = ST_FINISH;
        else                                    state_nxt_s = ST_RUN;
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters, address generators and the registered write stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rom_a_r      <= '0;
      reads_rem_r  <= '0;
      writes_rem_r <= '0;
      rd_pending_r <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_a_r      <= '0;
      ram_di_r     <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s == ST_RUN);
      done_r       <= (state_nxt_s == ST_FINISH);
      rd_pending_r <= rom_en_s;
      if ((state_r == ST_IDLE) && start) begin
        rom_a_r      <= src_base;
        reads_rem_r  <= count;
        writes_rem_r <= count;
        ram_a_r      <= dst_base;
      end else begin
        if (rom_en_s) begin
          rom_a_r     <= rom_a_r + ADR_WIDTH'(1);
          reads_rem_r <= reads_rem_r - CW'(1);
        end
        if (pop_s) begin
          writes_rem_r <= writes_rem_r - CW'(1);
          ram_a_r      <= ram_a_r + DST_AW'(1);
        end
      end
      if (load_s) begin
        ram_we_r <= wr_valid_s;
        if (wr_valid_s) ram_di_r <= wr_data_s;
      end
    end
  end

  copy_fifo2 u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (rom_Do),
    .count (fifo_count_s),
    .head  (fifo_head_s)
  );

  assign busy   = busy_r;
  assign done   = done_r;
  assign rom_EN = rom_en_s;
  assign rom_A  = rom_a_r;
  assign ram_WE = ram_we_r;
  assign ram_A  = ram_a_r;
  assign ram_Di = ram_di_r;

endmodule

// File: tb/tb_rom_boot_copier.sv
// Self-checking bench for rom_boot_copier: ROM model, expected-transfer queues
// and a per-cycle compare process, plus literal spot checks.
module tb_rom_boot_copier;

  localparam int MEM_WORDS = 8192;
  localparam int DST_AW    = 14;
  localparam int AW        = 13;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [AW-1:0]     src_base;
  logic [DST_AW-1:0] dst_base;
  logic [AW:0]       count;
  logic              busy, done, rom_EN, ram_WE;
  logic [AW-1:0]     rom_A;
  logic [31:0]       rom_Do = 32'h0;
  logic [DST_AW-1:0] ram_A;
  logic [31:0]       ram_Di;
  logic              ram_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;

  int exp_rd_q[$];
  int exp_wa_q[$];
  int exp_wd_q[$];
  int rlog[$];
  int wlog_a[$];
  longint wlog_d[$];

  int en_n, first_en, last_en, we_n, first_we, last_acc;
  int busy_n, busy_first, busy_last, done_n, done_rel;
  bit prev_stall = 1'b0;
  logic [DST_AW-1:0] prev_a;
  logic [31:0] prev_di;

  rom_boot_copier #(.MEM_WORDS(MEM_WORDS), .DST_AW(DST_AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .src_base(src_base), .dst_base(dst_base),
    .count(count), .busy(busy), .done(done), .rom_EN(rom_EN), .rom_A(rom_A),
    .rom_Do(rom_Do), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di),
    .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input int a);
    return 32'hA500_0000 + a;
  endfunction

  // ROM macro: one-cycle registered read.
  always @(posedge CLK) if (rom_EN) rom_Do <= rom_word(int'(rom_A));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every read, every accepted write, stall stability and the busy/done trace.
  always @(negedge CLK) begin
    int rel;
    rel = cyc - t0;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (rom_EN) begin
        en_n++;
        if (first_en < 0) first_en = rel;
        last_en = rel;
        rlog.push_back(int'(rom_A));
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got rom_A=%0h expected no read", rom_A);
        end else chk("rom_A", rom_A, exp_rd_q.pop_front());
      end
      if (ram_WE && ram_ready) begin
        we_n++;
        if (first_we < 0) first_we = rel;
        last_acc = rel;
        wlog_a.push_back(int'(ram_A));
        wlog_d.push_back(longint'(ram_Di));
        if (exp_wa_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got ram_A=%0h expected no write", ram_A);
        end else begin
          chk("ram_A", ram_A, exp_wa_q.pop_front());
          chk("ram_Di", ram_Di, longint'(exp_wd_q.pop_front()) & 64'hFFFF_FFFF);
        end
      end
      if (prev_stall) begin
        chk("stall_WE", ram_WE, 1);
        chk("stall_A", ram_A, prev_a);
        chk("stall_Di", ram_Di, prev_di);
      end
      prev_stall = ram_WE && !ram_ready;
      prev_a  = ram_A;
      prev_di = ram_Di;
      if (busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (done) begin
        done_n++;
        done_rel = rel;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic clear_stats();
    en_n = 0; first_en = -1; last_en = -1; we_n = 0; first_we = -1; last_acc = -1;
    busy_n = 0; busy_first = -1; busy_last = -1; done_n = 0; done_rel = -1;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
  endtask

  task automatic launch(input int src, input int dst, input int cnt);
    @(posedge CLK); #1;
    for (int i = 0; i < cnt; i++) begin
      exp_rd_q.push_back((src + i) % MEM_WORDS);
      exp_wa_q.push_back((dst + i) % (1 << DST_AW));
      exp_wd_q.push_back(int'(rom_word((src + i) % MEM_WORDS)));
    end
    clear_stats();
    t0 = cyc;
    src_base = AW'(src); dst_base = DST_AW'(dst); count = (AW+1)'(cnt);
    start = 1'b1; ram_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // pat 0: ram_ready held high; pat 1: ram_ready 1,0,0 repeating. restart pulses start at cycle 3.
  task automatic run_copy(input int src, input int dst, input int cnt, input int pat, input bit restart);
    int k;
    launch(src, dst, cnt);
    k = 0;
    while (done_n == 0 && k < 400) begin
      ram_ready = (pat == 0) ? 1'b1 : (((cyc - t0) % 3) == 0);
      if (restart && (cyc - t0) == 3) begin
        start = 1'b1; src_base = 13'h1000; dst_base = 14'h0000; count = 14'd5;
      end else start = 1'b0;
      @(posedge CLK); #1;
      k++;
    end
    start = 1'b0; ram_ready = 1'b1;
    if (done_n == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within 400 cycles expected done");
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("done_pulses", done_n, 1);
    chk("reads_left", exp_rd_q.size(), 0);
    chk("writes_left", exp_wa_q.size(), 0);
    if (pat == 0 && cnt > 0) begin
      chk("first_en", first_en, 1);
      chk("last_en", last_en, cnt);
      chk("en_cycles", en_n, cnt);
      chk("first_we", first_we, 3);
      chk("last_accept", last_acc, cnt + 2);
      chk("done_cycle", done_rel, cnt + 3);
      chk("busy_first", busy_first, 1);
      chk("busy_last", busy_last, cnt + 2);
      chk("busy_cycles", busy_n, cnt + 2);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; count = '0; ram_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_rom_EN", rom_EN, 0); chk("rst_rom_A", rom_A, 0);
    chk("rst_ram_WE", ram_WE, 0); chk("rst_ram_A", ram_A, 0);
    chk("rst_ram_Di", ram_Di, 0);
    RST = 1'b0;

    // Basic copy, full throughput.
    run_copy(32'h10, 32'h200, 4, 0, 1'b0);
    chk("t1_w0_data", wlog_d.size() > 0 ? wlog_d[0] : -1, 32'hA500_0010);
    chk("t1_w3_data", wlog_d.size() > 3 ? wlog_d[3] : -1, 32'hA500_0013);
    chk("t1_w3_addr", wlog_a.size() > 3 ? wlog_a[3] : -1, 32'h203);

    // Zero-length copy: no accesses, done at cycle 1, never busy.
    run_copy(32'h55, 32'h10, 0, 0, 1'b0);
    chk("z_en", en_n, 0);
    chk("z_we", we_n, 0);
    chk("z_done_cycle", done_rel, 1);
    chk("z_busy", busy_n, 0);

    // Backpressure 1,0,0 pattern.
    run_copy(32'h123, 32'h40, 8, 1, 1'b0);
    chk("bp_writes", we_n, 8);

    // ROM address wrap.
    run_copy(MEM_WORDS - 2, 32'h300, 4, 0, 1'b0);
    chk("wrap_r1", rlog.size() > 1 ? rlog[1] : -1, 8191);
    chk("wrap_r2", rlog.size() > 2 ? rlog[2] : -1, 0);

    // RAM address wrap.
    run_copy(32'h20, (1 << DST_AW) - 1, 2, 0, 1'b0);
    chk("dwrap_a0", wlog_a.size() > 0 ? wlog_a[0] : -1, 32'h3FFF);
    chk("dwrap_a1", wlog_a.size() > 1 ? wlog_a[1] : -1, 32'h0000);

    // start during busy is ignored.
    run_copy(32'h700, 32'h1000, 6, 0, 1'b1);

    // Reset mid-copy aborts with no done.
    launch(32'h40, 32'h100, 16);
    while ((cyc - t0) < 5) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    #1;
    chk("abort_busy", busy, 0);     chk("abort_rom_EN", rom_EN, 0);
    chk("abort_ram_WE", ram_WE, 0); chk("abort_ram_A", ram_A, 0);
    chk("abort_ram_Di", ram_Di, 0); chk("abort_rom_A", rom_A, 0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("abort_no_done", done_n, 0);
    chk("abort_idle_busy", busy, 0);

    // Fresh copy after abort.
    run_copy(32'h80, 32'h180, 5, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
